// File: rtl/eth_pkg.sv
// eth_pkg: shared constants, FSM encoding and header layout for eth_frame_buf.
// Optional feature macro: ETH_FRAME_BUF_HDR_EN (header word in each page).
package eth_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int PAGES      = 2;
    // Header word layout, counted from the MSB down:
    // {frame_cnt[15:0], ovf, zero pad, len[ADDR_W:0]}.
    localparam int HDR_CNT_W        = 16;
    localparam int HDR_OVF_FROM_MSB = 16;
    localparam int HDR_LEN_LSB      = 0;
    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } swap_state_t;
endpackage

// File: rtl/eth_sync_edge.sv
// eth_sync_edge: synchronises an active-low async sync line and pulses on its falling edge.
// Ports: clk, reset (async, active-high), din_n (async input), evt (one-cycle falling-edge pulse).
module eth_sync_edge
    import eth_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din_n,
    output logic evt
);
    logic [STAGES-1:0] sync;
    logic              prev;

    // Reset to the idle-high level so no spurious edge fires out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '1;
            prev <= 1'b1;
        end else begin
            sync <= {sync[STAGES-2:0], din_n};
            prev <= sync[STAGES-1];
        end
    end

    assign evt = prev & ~sync[STAGES-1];
endmodule

// File: rtl/eth_frame_buf.sv
// eth_frame_buf: ping-pong sample buffer feeding eth_send; a falling i_msync_n swaps pages.
// Ports: clk, reset (async, active-high); i_wr_vld/i_wr_data sample input; i_msync_n async sync;
// i_rd_addr/o_rd_data read page (1-cycle latency); i_rd_lock defers swaps;
// o_frame_rdy, o_frame_len, o_frame_cnt, o_ovf, o_sync_drop frame status.
// Optional feature macro: ETH_FRAME_BUF_HDR_EN reserves word 0 of each page for a header.
module eth_frame_buf
    import eth_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_vld,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_msync_n,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_rd_lock,
    output logic              o_frame_rdy,
    output logic [ADDR_W:0]   o_frame_len,
    output logic [15:0]       o_frame_cnt,
    output logic              o_ovf,
    output logic              o_sync_drop
);
    localparam int DEPTH = 1 << ADDR_W;
`ifdef ETH_FRAME_BUF_HDR_EN
    localparam logic [ADDR_W:0] START = (ADDR_W+1)'(1);
`else
    localparam logic [ADDR_W:0] START = '0;
`endif

    logic [DATA_W-1:0] mem [PAGES*DEPTH];
    swap_state_t       state_q, state_d;
    logic              fill_pg;
    logic [ADDR_W:0]   wptr;
    logic              ovf_fill;
    logic              sync_evt, swap, drop, full, we;
    logic [ADDR_W:0]   waddr;

    eth_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .din_n (i_msync_n),
        .evt   (sync_evt)
    );

    // A lock present in the same cycle as the sync always wins and defers the swap.
    always_comb begin
        state_d = state_q;
        swap    = 1'b0;
        drop    = 1'b0;
        if (state_q == IDLE) begin
            swap    = sync_evt & ~i_rd_lock;
            state_d = (sync_evt & i_rd_lock) ? PEND : IDLE;
        end else begin
            swap    = ~i_rd_lock;
            drop    = sync_evt;
            state_d = i_rd_lock ? PEND : IDLE;
        end
    end

    assign full = wptr[ADDR_W];
    // A write on the swap cycle belongs to the new fill page, which is always empty.
    assign we    = swap ? i_wr_vld : i_wr_vld & ~full;
    assign waddr = swap ? {~fill_pg, START[ADDR_W-1:0]} : {fill_pg, wptr[ADDR_W-1:0]};

`ifdef ETH_FRAME_BUF_HDR_EN
    logic [DATA_W-1:0] hdr;
    always_comb begin
        hdr = '0;
        hdr[DATA_W-1 -: HDR_CNT_W]          = o_frame_cnt + 16'd1;
        hdr[DATA_W-1-HDR_OVF_FROM_MSB]      = ovf_fill;
        hdr[HDR_LEN_LSB +: ADDR_W+1]        = wptr;
    end
`endif

    // Header goes through a second write port so it never collides with a sample write.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= i_wr_data;
`ifdef ETH_FRAME_BUF_HDR_EN
        if (swap)
            mem[{fill_pg, {ADDR_W{1'b0}}}] <= hdr;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            o_rd_data <= '0;
        else
            o_rd_data <= mem[{~fill_pg, i_rd_addr}];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            fill_pg     <= 1'b0;
            wptr        <= START;
            ovf_fill    <= 1'b0;
            o_frame_rdy <= 1'b0;
            o_frame_len <= '0;
            o_frame_cnt <= '0;
            o_ovf       <= 1'b0;
            o_sync_drop <= 1'b0;
        end else begin
            state_q     <= state_d;
            o_frame_rdy <= swap;
            o_sync_drop <= drop;
            if (swap) begin
                fill_pg     <= ~fill_pg;
                o_frame_len <= wptr;
                o_ovf       <= ovf_fill;
                ovf_fill    <= 1'b0;
                wptr        <= START + (ADDR_W+1)'(i_wr_vld);
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end else begin
                wptr        <= wptr + (ADDR_W+1)'(we);
                ovf_fill    <= ovf_fill | (i_wr_vld & full);
            end
        end
    end
endmodule

// File: tb/tb_eth_frame_buf.sv
// tb_eth_frame_buf: self-checking bench for eth_frame_buf (table-driven frames plus corner sequences).
module tb_eth_frame_buf;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int SS    = 2;
    localparam int DEPTH = 1 << AW;
`ifdef ETH_FRAME_BUF_HDR_EN
    localparam int START = 1;
`else
    localparam int START = 0;
`endif
    localparam int CAP = DEPTH - START;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_wr_vld = 1'b0;
    logic [DW-1:0] i_wr_data = '0;
    logic          i_msync_n = 1'b1;
    logic [AW-1:0] i_rd_addr = '0;
    logic [DW-1:0] o_rd_data;
    logic          i_rd_lock = 1'b0;
    logic          o_frame_rdy;
    logic [AW:0]   o_frame_len;
    logic [15:0]   o_frame_cnt;
    logic          o_ovf;
    logic          o_sync_drop;

    eth_frame_buf #(.ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_wr_vld    (i_wr_vld),
        .i_wr_data   (i_wr_data),
        .i_msync_n   (i_msync_n),
        .i_rd_addr   (i_rd_addr),
        .o_rd_data   (o_rd_data),
        .i_rd_lock   (i_rd_lock),
        .o_frame_rdy (o_frame_rdy),
        .o_frame_len (o_frame_len),
        .o_frame_cnt (o_frame_cnt),
        .o_ovf       (o_ovf),
        .o_sync_drop (o_sync_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       n;
        logic [31:0] base;
        int       exp_len;
        bit       exp_ovf;
    } vec_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          exp_cnt = 0;
    int          fill_n = 0;
    logic [DW-1:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_words(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            i_wr_vld  = 1'b1;
            i_wr_data = base + 32'(i);
            if (fill_n < CAP) begin
                exp_q.push_back(base + 32'(i));
                fill_n++;
            end
            tick();
        end
        i_wr_vld = 1'b0;
    endtask

    // Waits (bounded) for o_frame_rdy, checks status outputs, then reads the page back.
    task automatic frame_done(input string name, input int exp_lat, input int exp_len, input bit exp_ovf);
        int          lat;
        logic [31:0] h;
        lat = -1;
        for (int c = 0; c <= exp_lat + 8; c++) begin
            if (o_frame_rdy === 1'b1) begin
                lat = c;
                break;
            end
            tick();
        end
        exp_cnt = (exp_cnt + 1) & 16'hffff;
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " len"}, 64'(o_frame_len), 64'(exp_len));
        check({name, " ovf"}, 64'(o_ovf), 64'(exp_ovf));
        check({name, " cnt"}, 64'(o_frame_cnt), 64'(exp_cnt));
        tick();
        check({name, " rdy pulse width"}, 64'(o_frame_rdy), 64'd0);
`ifdef ETH_FRAME_BUF_HDR_EN
        h = {exp_cnt[15:0], exp_ovf, 4'b0, 11'(exp_len)};
        i_rd_addr = '0;
        tick();
        check({name, " header"}, 64'(o_rd_data), 64'(h));
`else
        h = '0;
`endif
        check({name, " queue depth"}, 64'(exp_q.size()), 64'(exp_len - START));
        for (int k = 0; exp_q.size() > 0; k++) begin
            i_rd_addr = AW'(START + k);
            tick();
            check({name, " rd data"}, 64'(o_rd_data), 64'(exp_q.pop_front()));
        end
        fill_n = 0;
    endtask

    task automatic sync_frame(input string name, input int exp_len, input bit exp_ovf);
        i_msync_n = 1'b0;
        frame_done(name, SS + 1, exp_len, exp_ovf);
        i_msync_n = 1'b1;
        repeat (SS + 2) tick();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [6];
        int          drops, rdys;
        logic [31:0] swap_word;

        vecs[0] = '{100,     32'h0000_0000, START + 100, 1'b0};
        vecs[1] = '{1030,    32'h0001_0000, START + CAP, 1'b1};
        vecs[2] = '{10,      32'h0002_0000, START + 10,  1'b0};
        vecs[3] = '{0,       32'h0003_0000, START,       1'b0};
        vecs[4] = '{CAP,     32'h0004_0000, START + CAP, 1'b0};
        vecs[5] = '{CAP + 1, 32'h0005_0000, START + CAP, 1'b1};

        repeat (3) tick();
        check("reset rdy", 64'(o_frame_rdy), 64'd0);
        check("reset len", 64'(o_frame_len), 64'd0);
        check("reset cnt", 64'(o_frame_cnt), 64'd0);
        check("reset ovf", 64'(o_ovf), 64'd0);
        check("reset drop", 64'(o_sync_drop), 64'd0);
        check("reset rd_data", 64'(o_rd_data), 64'd0);
        reset = 1'b0;
        repeat (SS + 2) tick();
        check("no event out of reset", 64'(o_frame_rdy), 64'd0);

        for (int i = 0; i < 6; i++) begin
            write_words(vecs[i].n, vecs[i].base);
            sync_frame($sformatf("vec%0d", i), vecs[i].exp_len, vecs[i].exp_ovf);
        end

        // Sync while locked: swap deferred until the cycle after release, extra writes included.
        write_words(20, 32'h5000_0000);
        i_rd_lock = 1'b1;
        i_msync_n = 1'b0;
        rdys = 0;
        repeat (SS + 4) begin
            tick();
            rdys += int'(o_frame_rdy);
        end
        check("lock no swap", 64'(rdys), 64'd0);
        write_words(5, 32'h5000_0014);
        i_msync_n = 1'b1;
        i_rd_lock = 1'b0;
        frame_done("lock", 1, START + 25, 1'b0);
        repeat (SS + 2) tick();

        // Two syncs while locked: one drop pulse, one swap after unlock.
        i_rd_lock = 1'b1;
        write_words(7, 32'h6000_0000);
        drops = 0;
        rdys  = 0;
        for (int p = 0; p < 4; p++) begin
            i_msync_n = p[0];
            repeat (4) begin
                tick();
                drops += int'(o_sync_drop);
                rdys  += int'(o_frame_rdy);
            end
        end
        check("dbl drop count", 64'(drops), 64'd1);
        check("dbl no swap", 64'(rdys), 64'd0);
        i_rd_lock = 1'b0;
        frame_done("dbl", 1, START + 7, 1'b0);
        repeat (SS + 2) tick();

        // Write on the swap cycle lands at the start of the new fill page.
        write_words(4, 32'h7000_0000);
        i_msync_n = 1'b0;
        repeat (SS) tick();
        swap_word = 32'hABCD_0001;
        i_wr_vld  = 1'b1;
        i_wr_data = swap_word;
        tick();
        i_wr_vld = 1'b0;
        frame_done("swapwr", 0, START + 4, 1'b0);
        exp_q.push_back(swap_word);
        fill_n = 1;
        i_msync_n = 1'b1;
        repeat (SS + 2) tick();
        write_words(2, 32'h7100_0000);
        sync_frame("after swapwr", START + 3, 1'b0);

        // Reset mid-frame discards the partial frame and clears status immediately.
        write_words(50, 32'h8000_0000);
        reset = 1'b1;
        #1;
        check("midrst rdy", 64'(o_frame_rdy), 64'd0);
        check("midrst len", 64'(o_frame_len), 64'd0);
        check("midrst cnt", 64'(o_frame_cnt), 64'd0);
        check("midrst ovf", 64'(o_ovf), 64'd0);
        check("midrst drop", 64'(o_sync_drop), 64'd0);
        check("midrst rd_data", 64'(o_rd_data), 64'd0);
        tick();
        reset = 1'b0;
        exp_q.delete();
        fill_n  = 0;
        exp_cnt = 0;
        repeat (SS + 2) tick();
        write_words(8, 32'h9000_0000);
        sync_frame("post reset", START + 8, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
